seq_detector_prog: RTL and testbench

Parametrised serial pattern detector with a run-time programmable pattern, length and overlap mode. It supersedes the fixed 4-state "1101" detector. It sits on a 1-bit serial data path, qualified by a valid strobe, and raises a single-cycle registered pulse whenever the last `cfg_len` accepted bits equal the programmed pattern. An optional saturating match counter can be compiled in for debug and statistics.

---
 rtl/seq_detector_prog.sv | 70 +++++++
 tb/tb_seq_detector_prog.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: serial pattern detector with run-time pattern, length and overlap mode
// Ports: clk; rst_n (async, active-low); data_valid/data_in (serial bit, accepted when valid);
// cfg_load latches cfg_pattern/cfg_len/cfg_overlap; pattern_found (registered match pulse);
// match_count (saturating, built only with SEQDET_MATCH_COUNT_EN, otherwise tied to 0).
module seq_detector_prog #(
  parameter int PAT_MAX = 8,
  parameter int LEN_W = $clog2(PAT_MAX + 1),
  parameter int CNT_W = 16,
  parameter logic [PAT_MAX-1:0] RST_PATTERN = PAT_MAX'(13),
  parameter logic [LEN_W-1:0] RST_LEN = LEN_W'(4),
  parameter logic RST_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               data_valid,
  input  logic               data_in,
  input  logic               cfg_load,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               pattern_found,
  output logic [CNT_W-1:0]   match_count
);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_MAX);
  logic [PAT_MAX-1:0] pat_q, hist_q, hist_d, mask;
  logic [LEN_W-1:0] len_q, len_d, fill_q, fill_d;
  logic ovl_q, found_q, match;
  always_comb begin
    hist_d = {hist_q[PAT_MAX-2:0], data_in};
    fill_d = fill_q == LEN_MAX ? fill_q : fill_q + 1'b1;
    // keeps only the low len_q bits of the history for the compare
    mask = {PAT_MAX{1'b1}} >> (LEN_MAX - len_q);
    match = data_valid && len_q != '0 && fill_d >= len_q && ((hist_d ^ pat_q) & mask) == '0;
    len_d = cfg_len > LEN_MAX ? LEN_MAX : cfg_len;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pat_q   <= RST_PATTERN;
      len_q   <= RST_LEN;
      ovl_q   <= RST_OVERLAP;
      hist_q  <= '0;
      fill_q  <= '0;
      found_q <= 1'b0;
    end else if (cfg_load) begin
      pat_q   <= cfg_pattern;
      len_q   <= len_d;
      ovl_q   <= cfg_overlap;
      hist_q  <= '0;
      fill_q  <= '0;
      found_q <= 1'b0;
    end else begin
      found_q <= match;
      if (data_valid) begin
        hist_q <= hist_d;
        // non-overlap mode forgets the matching bits so the next match needs a fresh run
        fill_q <= match && !ovl_q ? '0 : fill_d;
      end
    end
  assign pattern_found = found_q;
`ifdef SEQDET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (cfg_load) cnt_q <= '0;
    else if (match && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: table-driven checks of seq_detector_prog
module tb_seq_detector_prog;
`ifdef SEQDET_MATCH_COUNT_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, data_valid = 1'b0, data_in = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic pf, pf2;
  logic [15:0] mc;
  logic [1:0] mc2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  seq_detector_prog dut (
    .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data_in(data_in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .pattern_found(pf), .match_count(mc)
  );

  seq_detector_prog #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data_in(data_in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .pattern_found(pf2), .match_count(mc2)
  );

  typedef struct packed {
    logic ld; logic [7:0] pat; logic [3:0] len; logic ovl;
    logic v; logic d; logic pf; logic [15:0] cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic ld, logic [7:0] pat, logic [3:0] len, logic ovl,
                              logic v, logic d, logic epf, int cnt);
    vec_t e;
    e = '{ld, pat, len, ovl, v, d, epf, 16'(cnt)};
    tbl.push_back(e);
  endfunction
  function automatic void vb(logic d, logic epf, int cnt); add(1'b0, 8'h0, 4'h0, 1'b0, 1'b1, d, epf, cnt); endfunction
  function automatic void vg(logic d, int cnt); add(1'b0, 8'h0, 4'h0, 1'b0, 1'b0, d, 1'b0, cnt); endfunction
  function automatic void vl(logic [7:0] pat, logic [3:0] len, logic ovl); add(1'b1, pat, len, ovl, 1'b1, 1'b1, 1'b0, 0); endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      cfg_load = tbl[i].ld; cfg_pattern = tbl[i].pat; cfg_len = tbl[i].len; cfg_overlap = tbl[i].ovl;
      data_valid = tbl[i].v; data_in = tbl[i].d;
      @(posedge clk); #1;
      check($sformatf("%s[%0d].pf", name, i), 32'(pf), 32'(tbl[i].pf));
      check($sformatf("%s[%0d].cnt", name, i), 32'(mc), CEN ? 32'(tbl[i].cnt) : 32'd0);
    end
    cfg_load = 1'b0; data_valid = 1'b0;
    tbl.delete();
  endtask

  initial begin
    logic [3:0] gap_bits;
    logic [15:0] sat_bits;
    int n;
    #12;
    check("reset.pf", 32'(pf), 32'd0);
    check("reset.cnt", 32'(mc), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // reset defaults (1101, len 4, overlap)
    vb(1, 0, 0); vb(1, 0, 0); vb(0, 0, 0); vb(1, 1, 1); vb(1, 0, 1); vb(0, 0, 1); vb(1, 1, 2);
    // 101 non-overlap, then overlap
    vl(8'h05, 4'd3, 1'b0);
    vb(1, 0, 0); vb(0, 0, 0); vb(1, 1, 1); vb(0, 0, 1); vb(1, 0, 1);
    vl(8'h05, 4'd3, 1'b1);
    vb(1, 0, 0); vb(0, 0, 0); vb(1, 1, 1); vb(0, 0, 1); vb(1, 1, 2);
    // valid gaps with data_in toggling while invalid
    vl(8'h0D, 4'd4, 1'b1);
    gap_bits = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      vb(gap_bits[k], k == 3, k == 3 ? 1 : 0);
      for (int j = 0; j < 3; j++) vg(j[0] ^ ~gap_bits[k], k == 3 ? 1 : 0);
    end
    // length clamp: 10 -> 8, all ones
    vl(8'hFF, 4'd10, 1'b1);
    for (int k = 0; k < 8; k++) vb(1, k == 7, k == 7 ? 1 : 0);
    vb(1, 1, 2);
    // length 0 disables matching
    vl(8'h00, 4'd0, 1'b1);
    for (int k = 0; k < 6; k++) vb(k < 4 ? 1'b0 : 1'b1, 0, 0);
    // cfg_load wins over a coincident data bit and clears the count
    vl(8'h0D, 4'd4, 1'b1);
    vb(1, 0, 0); vb(1, 0, 0); vb(0, 0, 0); vb(1, 1, 1); vb(1, 0, 1); vb(0, 0, 1);
    vl(8'h0D, 4'd4, 1'b1);
    vb(1, 0, 0); vb(1, 0, 0); vb(0, 0, 0); vb(1, 1, 1);
    run_tbl("tbl");

    // asynchronous reset mid-operation restores default config
    vl(8'h05, 4'd3, 1'b1);
    vb(1, 0, 0); vb(0, 0, 0); vb(1, 1, 1);
    run_tbl("pre_rst");
    #1 rst_n = 1'b0;
    #1;
    check("rst_async.pf", 32'(pf), 32'd0);
    check("rst_async.cnt", 32'(mc), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    vb(1, 0, 0); vb(0, 0, 0); vb(1, 0, 0); vb(1, 0, 0); vb(0, 0, 0); vb(1, 1, 1);
    run_tbl("post_rst");

    // five matches: 16-bit count reaches 5, 2-bit count saturates at 3
    vl(8'h0D, 4'd4, 1'b1);
    sat_bits = 16'b1011011011011011;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      if (k % 3 == 0 && k > 0) n++;
      vb(sat_bits[k], k % 3 == 0 && k > 0, n);
    end
    run_tbl("sat");
    check("sat.cnt2", 32'(mc2), CEN ? 32'd3 : 32'd0);
    check("sat.cnt16", 32'(mc), CEN ? 32'd5 : 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
